// File: rtl/pc_seq_ctrl_pkg.sv
// Shared encodings and defaults for the PC fetch/update sequencer.
package pc_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_UPDATE = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    PCSRC_SEQ = 2'b00,
    PCSRC_BR  = 2'b01,
    PCSRC_JR  = 2'b10,
    PCSRC_J   = 2'b11
  } pcsrc_t;

  localparam logic [5:0]  HALT_OP_DEFAULT       = 6'b111111;
  localparam logic [29:0] RESET_PC_DEFAULT      = 30'h0000_0C00;
  localparam int          FETCH_TIMEOUT_DEFAULT = 16;

  // Branch offsets are word offsets, so they are widened straight to PC width.
  function automatic logic [29:0] sext16(input logic [15:0] imm);
    return {{14{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/pc_seq_ctrl_npc_calc.sv
// Combinational next-PC selection: sequential, branch, register jump, direct jump.
module npc_calc
  import pc_seq_ctrl_pkg::*;
(
  input  logic [29:0] PC,
  input  logic [25:0] instr_index,
  input  logic [1:0]  PCSrc,
  input  logic        BranchTaken,
  input  logic [29:0] target,
  output logic [29:0] npc
);

  logic [29:0] pc1;

  assign pc1 = PC + 30'd1;

  always_comb begin
    npc = pc1;
    case (pcsrc_t'(PCSrc))
      PCSRC_SEQ: npc = pc1;
      PCSRC_BR:  if (BranchTaken) npc = pc1 + sext16(instr_index[15:0]);
      PCSRC_JR:  npc = target;
      PCSRC_J:   npc = {pc1[29:26], instr_index};
    endcase
  end

endmodule

// File: rtl/pc_seq_ctrl.sv
// Multi-cycle fetch/decode/exec/update sequencer owning the PC write enable and next address.
module pc_seq_ctrl
  import pc_seq_ctrl_pkg::*;
#(
  parameter logic [29:0] RESET_PC      = RESET_PC_DEFAULT,
  parameter logic [5:0]  HALT_OP       = HALT_OP_DEFAULT,
  parameter int          FETCH_TIMEOUT = FETCH_TIMEOUT_DEFAULT
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [29:0] PC,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic [31:0] IR,
  input  logic [1:0]  PCSrc,
  input  logic        BranchTaken,
  input  logic [31:0] RegTarget,
  output logic        exec_start,
  input  logic        exec_done,
  input  logic        stall,
  output logic [29:0] NPC,
  output logic        PCWre,
  output logic        halted,
  output logic        fetch_err
);

  localparam int CNT_W = (FETCH_TIMEOUT > 2) ? $clog2(FETCH_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FETCH_TIMEOUT - 1);

  state_t           state;
  logic [31:0]      ir_q;
  logic [29:0]      npc_q;
  logic [29:0]      npc_next;
  logic [CNT_W-1:0] fetch_cnt;
  logic             halted_q;
  logic             fetch_err_q;
  logic             unused_regtarget_lsbs;

  // Targets are word aligned, so the byte offset of the jr register is dropped.
  assign unused_regtarget_lsbs = ^RegTarget[1:0];

  npc_calc u_npc_calc (
    .PC          (PC),
    .instr_index (ir_q[25:0]),
    .PCSrc       (PCSrc),
    .BranchTaken (BranchTaken),
    .target      (RegTarget[31:2]),
    .npc         (npc_next)
  );

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state       <= S_FETCH;
      ir_q        <= '0;
      npc_q       <= RESET_PC;
      fetch_cnt   <= '0;
      halted_q    <= 1'b0;
      fetch_err_q <= 1'b0;
    end else begin
      case (state)
        // An ack on the last allowed cycle still wins over the timeout.
        S_FETCH: begin
          if (imem_ack) begin
            ir_q      <= imem_data;
            fetch_cnt <= '0;
            state     <= S_DECODE;
          end else if (fetch_cnt == CNT_LAST) begin
            fetch_cnt   <= '0;
            fetch_err_q <= 1'b1;
            halted_q    <= 1'b1;
            state       <= S_HALT;
          end else begin
            fetch_cnt <= fetch_cnt + 1'b1;
          end
        end
        S_DECODE: begin
          if (ir_q[31:26] == HALT_OP) begin
            halted_q <= 1'b1;
            state    <= S_HALT;
          end else begin
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (exec_done) begin
            npc_q <= npc_next;
            state <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          if (!stall) state <= S_FETCH;
        end
        S_HALT: state <= S_HALT;
        default: begin
          halted_q <= 1'b1;
          state    <= S_HALT;
        end
      endcase
    end
  end

  // Request is held off while reset is asserted even though the reset state is FETCH.
  assign imem_req   = Reset && (state == S_FETCH);
  assign exec_start = (state == S_DECODE) && (ir_q[31:26] != HALT_OP);
  assign PCWre      = (state == S_UPDATE) && !stall;
  assign halted     = halted_q;
  assign fetch_err  = fetch_err_q;
  assign NPC        = halted_q ? 30'd0 : npc_q;
  assign IR         = halted_q ? 32'd0 : ir_q;

endmodule
